// File: rtl/mod_n_counter_pkg.sv
// Shared constants, direction type and load clamping helper for the modulo-N counter.
package mod_counter_pkg;

    localparam int unsigned DEF_MODULUS = 10;
    localparam int unsigned DEF_DIGITS  = 2;

    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } dir_t;

    // Out-of-range digit values saturate to the largest legal digit.
    function automatic int unsigned clamp_digit(input int unsigned value, input int unsigned modulus);
        return (value >= modulus) ? (modulus - 1) : value;
    endfunction

endpackage

// File: rtl/mod_n_counter_if.sv
// Control/status bundle of mod_n_counter; master drives controls, slave is the counter.
import mod_counter_pkg::*;

interface mod_n_counter_if #(
    parameter int unsigned MODULUS = DEF_MODULUS,
    parameter int unsigned DIGITS  = DEF_DIGITS
);
    localparam int unsigned W = $clog2(MODULUS);

    logic                  en;
    logic                  up;
    logic                  load;
    logic [DIGITS*W-1:0]   load_val;
    logic [DIGITS*W-1:0]   count;
    logic                  tc;
    logic                  wrapped;

    modport master (
        output en, up, load, load_val,
        input  count, tc, wrapped
    );

    modport slave (
        input  en, up, load, load_val,
        output count, tc, wrapped
    );

endinterface

// File: rtl/mod_n_counter_digit.sv
// One modulo-N digit: synchronous clamped load, step in either direction, terminal flag.
module mod_n_digit
    import mod_counter_pkg::*;
#(
    parameter int unsigned MODULUS = DEF_MODULUS
) (
    input  logic                         clk,
    input  logic                         clear_n,
    input  logic                         step,
    input  logic                         up,
    input  logic                         load,
    input  logic [$clog2(MODULUS)-1:0]   ld_val,
    output logic [$clog2(MODULUS)-1:0]   q,
    output logic                         at_term
);
    localparam int unsigned     W       = $clog2(MODULUS);
    localparam logic [W-1:0]    MAX_VAL = W'(MODULUS - 1);

    dir_t           dir;
    logic [W-1:0]   nxt;

    assign dir = dir_t'(up);

    always_comb begin
        nxt = q;
        if (dir == DIR_UP) begin
            nxt = (q == MAX_VAL) ? '0 : q + W'(1);
        end else begin
            nxt = (q == '0) ? MAX_VAL : q - W'(1);
        end
    end

    assign at_term = (dir == DIR_UP) ? (q == MAX_VAL) : (q == '0);

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            q <= '0;
        end else if (load) begin
            q <= W'(clamp_digit(32'(ld_val), MODULUS));
        end else if (step) begin
            q <= nxt;
        end
    end

endmodule

// File: rtl/mod_n_counter.sv
// Synchronous multi-digit modulo-N up/down counter with combinational carry/borrow chain.
// Build option: define MODCNT_SATURATE_EN to hold at the terminal value instead of wrapping.
module mod_n_counter
    import mod_counter_pkg::*;
#(
    parameter int unsigned MODULUS = DEF_MODULUS,
    parameter int unsigned DIGITS  = DEF_DIGITS
) (
    input  logic              clk,
    input  logic              clear_n,
    mod_n_counter_if.slave    bus
);
    localparam int unsigned W = $clog2(MODULUS);

    logic [DIGITS-1:0]  at_term;
    logic [DIGITS-1:0]  step;
    logic               all_term;
    logic               en_eff;
    logic               tc;

    assign all_term = &at_term;
    assign tc       = bus.en & ~bus.load & all_term;
    assign bus.tc   = tc;

`ifdef MODCNT_SATURATE_EN
    // Suppressing every step at the terminal value freezes the whole chain there.
    assign en_eff      = bus.en & ~all_term;
    assign bus.wrapped = 1'b0;
`else
    assign en_eff = bus.en;

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            bus.wrapped <= 1'b0;
        end else begin
            bus.wrapped <= tc;
        end
    end
`endif

    always_comb begin
        step    = '0;
        step[0] = en_eff;
        for (int unsigned i = 1; i < DIGITS; i++) begin
            step[i] = step[i-1] & at_term[i-1];
        end
    end

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        mod_n_digit #(
            .MODULUS (MODULUS)
        ) u_digit (
            .clk     (clk),
            .clear_n (clear_n),
            .step    (step[g]),
            .up      (bus.up),
            .load    (bus.load),
            .ld_val  (bus.load_val[g*W +: W]),
            .q       (bus.count[g*W +: W]),
            .at_term (at_term[g])
        );
    end

endmodule

// File: tb/tb_mod_n_counter.sv
// Directed bench: 2-digit decade counter plus a 1-digit modulo-6 instance.
module tb_mod_n_counter;

    logic clk = 1'b0;
    logic clear_n;
    logic clear_n_b;
    int   checks   = 0;
    int   failures = 0;

    mod_n_counter_if #(.MODULUS(10), .DIGITS(2)) ifa ();
    mod_n_counter_if #(.MODULUS(6),  .DIGITS(1)) ifb ();

    mod_n_counter #(.MODULUS(10), .DIGITS(2)) dut_a (
        .clk     (clk),
        .clear_n (clear_n),
        .bus     (ifa)
    );

    mod_n_counter #(.MODULUS(6), .DIGITS(1)) dut_b (
        .clk     (clk),
        .clear_n (clear_n_b),
        .bus     (ifb)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       load;
        logic       en;
        logic       up;
        logic [7:0] lv;
        logic       tc_pre;
        logic [7:0] cnt;
        logic       wr;
    } vec_t;

    vec_t vecs[20];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] bcd(input int unsigned v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int unsigned exp_b;
        vecs[0]  = '{1'b1, 1'b0, 1'b1, 8'h57, 1'b0, 8'h57, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 8'h58, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 8'h59, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 8'h60, 1'b0};
        vecs[4]  = '{1'b1, 1'b1, 1'b1, 8'h57, 1'b0, 8'h57, 1'b0};
        vecs[5]  = '{1'b1, 1'b1, 1'b1, 8'hAF, 1'b0, 8'h99, 1'b0};
        vecs[6]  = '{1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 8'h99, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 1'b1, 8'h00, 1'b1, 8'h00, 1'b1};
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 8'h99, 1'b1};
        vecs[9]  = '{1'b0, 1'b1, 1'b1, 8'h00, 1'b1, 8'h00, 1'b1};
        vecs[10] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 8'h99, 1'b1};
        vecs[11] = '{1'b1, 1'b0, 1'b0, 8'h3C, 1'b0, 8'h39, 1'b0};
        vecs[12] = '{1'b1, 1'b0, 1'b1, 8'h09, 1'b0, 8'h09, 1'b0};
        vecs[13] = '{1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 8'h10, 1'b0};
        vecs[14] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h09, 1'b0};
        vecs[15] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h08, 1'b0};
        vecs[16] = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0};
        vecs[17] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0};
        vecs[18] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 8'h99, 1'b1};
        vecs[19] = '{1'b1, 1'b0, 1'b1, 8'hF9, 1'b0, 8'h99, 1'b0};

        clear_n      = 1'b0;
        clear_n_b    = 1'b0;
        ifa.en       = 1'b0;
        ifa.up       = 1'b0;
        ifa.load     = 1'b0;
        ifa.load_val = '0;
        ifb.en       = 1'b0;
        ifb.up       = 1'b0;
        ifb.load     = 1'b0;
        ifb.load_val = '0;

        // Reset state and reset-time terminal flag
        #2;
        chk("rst_count", 32'(ifa.count), 32'h00);
        chk("rst_wrapped", 32'(ifa.wrapped), 32'h0);
        ifa.en = 1'b1;
        #1;
        chk("rst_tc_down", 32'(ifa.tc), 32'h1);
        ifa.up = 1'b1;
        #1;
        chk("rst_tc_up", 32'(ifa.tc), 32'h0);
        tick();
        chk("rst_hold_edge", 32'(ifa.count), 32'h00);
        @(negedge clk);
        clear_n = 1'b1;

        // Full up-count cycle 00..99 then 00
        for (int i = 1; i <= 100; i++) begin
            tick();
            chk($sformatf("t1_count[%0d]", i), 32'(ifa.count), 32'(bcd(i % 100)));
            chk($sformatf("t1_tc[%0d]", i), 32'(ifa.tc), 32'((i % 100) == 99));
            chk($sformatf("t1_wrapped[%0d]", i), 32'(ifa.wrapped), 32'(i == 100));
        end

        // Asynchronous clear during the wrapped cycle
        clear_n = 1'b0;
        #1;
        chk("t2_clr_count", 32'(ifa.count), 32'h00);
        chk("t2_clr_wrapped", 32'(ifa.wrapped), 32'h0);
        ifa.up = 1'b0;
        @(negedge clk);
        clear_n = 1'b1;
        tick();
        chk("t2_count_99", 32'(ifa.count), 32'h99);
        chk("t2_wrapped_99", 32'(ifa.wrapped), 32'h1);
        tick();
        chk("t2_count_98", 32'(ifa.count), 32'h98);
        chk("t2_wrapped_98", 32'(ifa.wrapped), 32'h0);
        tick();
        chk("t2_count_97", 32'(ifa.count), 32'h97);

        // Table: load/clamp/priority/direction changes
        for (int i = 0; i < 20; i++) begin
            ifa.load     = vecs[i].load;
            ifa.en       = vecs[i].en;
            ifa.up       = vecs[i].up;
            ifa.load_val = vecs[i].lv;
            #1;
            chk($sformatf("vec_tc[%0d]", i), 32'(ifa.tc), 32'(vecs[i].tc_pre));
            tick();
            chk($sformatf("vec_count[%0d]", i), 32'(ifa.count), 32'(vecs[i].cnt));
            chk($sformatf("vec_wrapped[%0d]", i), 32'(ifa.wrapped), 32'(vecs[i].wr));
        end

        // Clear mid-count overrides load and en; counting resumes after release
        ifa.load     = 1'b1;
        ifa.en       = 1'b0;
        ifa.load_val = 8'h41;
        tick();
        ifa.load = 1'b0;
        ifa.en   = 1'b1;
        ifa.up   = 1'b1;
        tick();
        chk("t5_count_42", 32'(ifa.count), 32'h42);
        #1;
        clear_n = 1'b0;
        #1;
        chk("t5_clr_immediate", 32'(ifa.count), 32'h00);
        ifa.load     = 1'b1;
        ifa.load_val = 8'h55;
        tick();
        chk("t5_clr_over_load", 32'(ifa.count), 32'h00);
        ifa.load = 1'b0;
        @(negedge clk);
        clear_n = 1'b1;
        tick();
        chk("t5_resume_01", 32'(ifa.count), 32'h01);
        tick();
        chk("t5_resume_02", 32'(ifa.count), 32'h02);

        // Modulo-6 single digit: wrap (default) or saturate (MODCNT_SATURATE_EN)
        ifb.en = 1'b1;
        ifb.up = 1'b1;
        @(negedge clk);
        clear_n_b = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            tick();
`ifdef MODCNT_SATURATE_EN
            exp_b = (i > 5) ? 5 : i;
            chk($sformatf("m6_wrapped[%0d]", i), 32'(ifb.wrapped), 32'h0);
`else
            exp_b = i % 6;
            chk($sformatf("m6_wrapped[%0d]", i), 32'(ifb.wrapped), 32'(i == 6));
`endif
            chk($sformatf("m6_count[%0d]", i), 32'(ifb.count), 32'(exp_b));
            chk($sformatf("m6_tc[%0d]", i), 32'(ifb.tc), 32'(exp_b == 5));
        end
        ifb.load     = 1'b1;
        ifb.en       = 1'b0;
        ifb.load_val = 3'h7;
        tick();
        chk("m6_clamp", 32'(ifb.count), 32'h5);
        ifb.load_val = 3'h0;
        tick();
        chk("m6_load0", 32'(ifb.count), 32'h0);
        ifb.load = 1'b0;
        ifb.en   = 1'b1;
        ifb.up   = 1'b0;
        #1;
        chk("m6_tc_down", 32'(ifb.tc), 32'h1);
        tick();
`ifdef MODCNT_SATURATE_EN
        chk("m6_down_count", 32'(ifb.count), 32'h0);
        chk("m6_down_wrapped", 32'(ifb.wrapped), 32'h0);
`else
        chk("m6_down_count", 32'(ifb.count), 32'h5);
        chk("m6_down_wrapped", 32'(ifb.wrapped), 32'h1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
